// File: rtl/avalon_mm_slave_regfile_if.sv
// Avalon-MM bus bundle between a master and avalon_mm_slave_regfile.
// byteenable exists only when AVS_BYTEENABLE_EN is defined.
interface avalon_mm_slave_regfile_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) ();
    logic [AW-1:0]   address;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
`ifdef AVS_BYTEENABLE_EN
    logic [DW/8-1:0] byteenable;
`endif
    logic [DW-1:0]   readdata;
    logic            waitrequest;

    modport master (
`ifdef AVS_BYTEENABLE_EN
        output byteenable,
`endif
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
`ifdef AVS_BYTEENABLE_EN
        input  byteenable,
`endif
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_mm_slave_regfile.sv
// Avalon-MM slave register bank with WAIT_CYCLES wait states per transfer.
// Optional per-byte write lanes when AVS_BYTEENABLE_EN is defined.
module avalon_mm_slave_regfile #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                      clk,
    input logic                      reset,
    avalon_mm_slave_regfile_if.slave avs
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic          wait_q, wait_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic          addr_ok;
    logic [IW-1:0] idx;
    logic          load_rd;

    assign addr_ok = (32'(avs.address) < DEPTH);
    assign idx     = avs.address[IW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        load_rd = 1'b0;
        case (state_q)
            StIdle: begin
                if (avs.read || avs.write) begin
                    // A simultaneous read and write is handled as a write.
                    op_wr_d = avs.write;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                        load_rd = !avs.write;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (!avs.read && !avs.write) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                    load_rd = !op_wr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
                if (op_wr_q && addr_ok) begin
`ifdef AVS_BYTEENABLE_EN
                    for (int b = 0; b < DW / 8; b++) begin
                        if (avs.byteenable[b]) begin
                            mem_d[idx][8*b +: 8] = avs.writedata[8*b +: 8];
                        end
                    end
`else
                    mem_d[idx] = avs.writedata;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        if (load_rd) begin
            rdata_d = addr_ok ? mem_q[idx] : '0;
        end
        wait_d = (state_d != StAck);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            wait_q  <= 1'b1;
            rdata_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
        end
    end

    assign avs.waitrequest = wait_q;
    assign avs.readdata    = rdata_q;
endmodule

// File: tb/tb_avalon_mm_slave_regfile.sv
// Directed bench for avalon_mm_slave_regfile: three instances (default, DEPTH=16,
// WAIT_CYCLES=0) share one stimulus bus, gated by sel.
module tb_avalon_mm_slave_regfile;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic [1:0]  sel = 2'd0;
    logic        wait_m;
    logic [31:0] rdata_m;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] got;

    always #5 clk = ~clk;

    avalon_mm_slave_regfile_if #(.AW(8), .DW(32)) bus0 ();
    avalon_mm_slave_regfile_if #(.AW(8), .DW(32)) bus1 ();
    avalon_mm_slave_regfile_if #(.AW(8), .DW(32)) bus2 ();

    assign bus0.address = addr;
    assign bus1.address = addr;
    assign bus2.address = addr;
    assign bus0.writedata = wdata;
    assign bus1.writedata = wdata;
    assign bus2.writedata = wdata;
    assign bus0.read  = rd && (sel == 2'd0);
    assign bus0.write = wr && (sel == 2'd0);
    assign bus1.read  = rd && (sel == 2'd1);
    assign bus1.write = wr && (sel == 2'd1);
    assign bus2.read  = rd && (sel == 2'd2);
    assign bus2.write = wr && (sel == 2'd2);
`ifdef AVS_BYTEENABLE_EN
    assign bus0.byteenable = be;
    assign bus1.byteenable = be;
    assign bus2.byteenable = be;
`endif

    avalon_mm_slave_regfile #(.AW(8), .DW(32), .DEPTH(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .avs(bus0.slave)
    );
    avalon_mm_slave_regfile #(.AW(8), .DW(32), .DEPTH(16), .WAIT_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset), .avs(bus1.slave)
    );
    avalon_mm_slave_regfile #(.AW(8), .DW(32), .DEPTH(256), .WAIT_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .avs(bus2.slave)
    );

    always_comb begin
        wait_m  = bus0.waitrequest;
        rdata_m = bus0.readdata;
        case (sel)
            2'd1: begin wait_m = bus1.waitrequest; rdata_m = bus1.readdata; end
            2'd2: begin wait_m = bus2.waitrequest; rdata_m = bus2.readdata; end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request right after an edge; exp_lat = edges until waitrequest is seen low.
    task automatic xfer(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int exp_lat, input string tag,
                        output logic [31:0] rdata_o);
        int k;
        addr = a; rd = r; wr = w; wdata = d; be = b;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (wait_m && k < 40);
        check_eq({tag, "_lat"}, k, exp_lat);
        rdata_o = rdata_m;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        check_eq({tag, "_wr_hi"}, {31'b0, wait_m}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("rst_wait", {31'b0, bus0.waitrequest}, 32'd1);
            check_eq("rst_rdata", bus0.readdata, 32'h0);
        end

        sel = 2'd0;
        xfer(1'b1, 1'b0, 8'h10, 32'h0, 4'hF, 3, "rd10", got);
        check_eq("rd10_data", got, 32'h0);
        xfer(1'b0, 1'b1, 8'h2A, 32'hDEADBEEF, 4'hF, 3, "wr2a", got);
        xfer(1'b1, 1'b0, 8'h2A, 32'h0, 4'hF, 3, "rd2a", got);
        check_eq("rd2a_data", got, 32'hDEADBEEF);

        xfer(1'b1, 1'b1, 8'h05, 32'hA5A5A5A5, 4'hF, 3, "rw05", got);
        check_eq("rw05_rdata_kept", got, 32'hDEADBEEF);
        xfer(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, 3, "rd05", got);
        check_eq("rd05_data", got, 32'hA5A5A5A5);

        // Reset sampled at the edge that would otherwise enter ACK.
        xfer(1'b0, 1'b1, 8'h07, 32'h55555555, 4'hF, 3, "wr07a", got);
        addr = 8'h07; wr = 1'b1; wdata = 32'h11111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_wait_wait", {31'b0, bus0.waitrequest}, 32'd1);
        reset = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        xfer(1'b1, 1'b0, 8'h07, 32'h0, 4'hF, 3, "rd07r", got);
        check_eq("rd07_after_rst", got, 32'h0);

        xfer(1'b0, 1'b1, 8'h07, 32'h33333333, 4'hF, 3, "wr07b", got);
        addr = 8'h07; wr = 1'b1; wdata = 32'h44444444;
        @(posedge clk); #1;
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("drop_wait", {31'b0, bus0.waitrequest}, 32'd1);
        end
        xfer(1'b1, 1'b0, 8'h07, 32'h0, 4'hF, 3, "rd07d", got);
        check_eq("rd07_after_drop", got, 32'h33333333);

        sel = 2'd1;
        xfer(1'b0, 1'b1, 8'h20, 32'h12345678, 4'hF, 3, "s_wr20", got);
        xfer(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 3, "s_rd20", got);
        check_eq("s_rd20_data", got, 32'h0);
        xfer(1'b1, 1'b0, 8'h00, 32'h0, 4'hF, 3, "s_rd00", got);
        check_eq("s_rd00_alias", got, 32'h0);
        xfer(1'b0, 1'b1, 8'h03, 32'hCAFEF00D, 4'hF, 3, "s_wr03", got);
        xfer(1'b1, 1'b0, 8'h03, 32'h0, 4'hF, 3, "s_rd03", got);
        check_eq("s_rd03_data", got, 32'hCAFEF00D);

        sel = 2'd2;
        xfer(1'b1, 1'b0, 8'h03, 32'h0, 4'hF, 1, "z_rd03", got);
        check_eq("z_rd03_data", got, 32'h0);
        xfer(1'b0, 1'b1, 8'h09, 32'h0BADF00D, 4'hF, 1, "z_wr09", got);
        xfer(1'b1, 1'b0, 8'h09, 32'h0, 4'hF, 1, "z_rd09", got);
        check_eq("z_rd09_data", got, 32'h0BADF00D);

`ifdef AVS_BYTEENABLE_EN
        for (int s = 0; s < 3; s += 2) begin
            int lat;
            sel = 2'(s);
            lat = (s == 2) ? 1 : 3;
            xfer(1'b0, 1'b1, 8'h01, 32'hFFFFFFFF, 4'hF, lat, "be_full", got);
            xfer(1'b0, 1'b1, 8'h01, 32'h00AB0000, 4'b0100, lat, "be_lane2", got);
            xfer(1'b1, 1'b0, 8'h01, 32'h0, 4'h0, lat, "be_rd1", got);
            check_eq("be_rd1_data", got, 32'hFFABFFFF);
            xfer(1'b0, 1'b1, 8'h01, 32'h12345678, 4'b0000, lat, "be_none", got);
            xfer(1'b1, 1'b0, 8'h01, 32'h0, 4'hF, lat, "be_rd2", got);
            check_eq("be_rd2_data", got, 32'hFFABFFFF);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
